// File: rtl/aoi_eval_arbiter.sv
// Round-robin arbiter that shares one registered AND-OR-INVERT stage, q = ~((a & b) | c),
// among NUM_REQ requesters and returns each tagged result over a valid/ready channel.
module aoi_eval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_a,
  input  logic [NUM_REQ-1:0] op_b,
  input  logic [NUM_REQ-1:0] op_c,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_q,
  input  logic               rsp_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic           take;
  logic           cap_a, cap_b, cap_c;
  logic [IDW-1:0] cap_id;

  // Rotating priority search starting at rr_ptr; the sum is one bit wider so the
  // modulo wrap stays correct for NUM_REQ values that are not powers of two.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path through the block can leave it unassigned and infer a latch.
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      idx = sum[IDW-1:0];
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign take       = (state == IDLE) && gnt_found;
  assign rr_ptr_nxt = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
  assign busy       = (state != IDLE);

  // Grant is suppressed while rst is high even though state is already IDLE.
  always_comb begin
    gnt = '0;
    if (take && !rst) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      cap_a     <= 1'b0;
      cap_b     <= 1'b0;
      cap_c     <= 1'b0;
      cap_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= 1'b0;
    end else begin
      if (take) begin
        cap_a  <= op_a[gnt_idx];
        cap_b  <= op_b[gnt_idx];
        cap_c  <= op_c[gnt_idx];
        cap_id <= gnt_idx;
        rr_ptr <= rr_ptr_nxt;
      end
      if (state == EVAL) begin
        rsp_q     <= ~((cap_a & cap_b) | cap_c);
        rsp_id    <= cap_id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aoi_eval_arbiter.sv
// Directed self-checking bench for aoi_eval_arbiter with NUM_REQ=4: reset, truth table,
// round-robin order and spacing, backpressure, mid-operation reset and dropped requests.
module tb_aoi_eval_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req, op_a, op_b, op_c, gnt;
  logic               rsp_valid, rsp_q, rsp_ready, busy;
  logic [IDW-1:0]     rsp_id;

  int checks = 0;
  int errors = 0;

  aoi_eval_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; op_a = '0; op_b = '0; op_c = '0; rsp_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_q !== 1'b0) begin errors++; $display("FAIL reset_q got=%b exp=0", rsp_q); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt_held got=%b exp=0000", gnt); end
    req = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    req = 4'b0001; op_a = 4'b0001; op_b = 4'b0001; op_c = 4'b0000; rsp_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt got=%b exp=0001", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_T got=%b exp=0", busy); end
    tick();
    req = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_T1 got=%b exp=1", busy); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_gnt_eval got=%b exp=0000", gnt); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_T1 got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_T2 got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_q !== 1'b0) begin errors++; $display("FAIL basic_q got=%b exp=0", rsp_q); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_T2 got=%b exp=1", busy); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_T3 got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_T3 got=%b exp=0", busy); end
  endtask

  // Expected q indexed by {a,b,c}: high only for 000, 010, 100.
  task automatic test_truth_table();
    logic [7:0] exp_q;
    logic [2:0] abc;
    exp_q = 8'b0001_0101;
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      abc  = 3'(v);
      req  = 4'b0100;
      op_a = {1'b0, abc[2], 2'b00};
      op_b = {1'b0, abc[1], 2'b00};
      op_c = {1'b0, abc[0], 2'b00};
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL tt_gnt abc=%b got=%b exp=0100", abc, gnt); end
      tick();
      req = '0; op_a = '0; op_b = '0; op_c = '0;
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL tt_valid abc=%b got=%b exp=1", abc, rsp_valid); end
      checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL tt_id abc=%b got=%0d exp=2", abc, rsp_id); end
      checks++; if (rsp_q !== exp_q[v]) begin errors++; $display("FAIL tt_q abc=%b got=%b exp=%b", abc, rsp_q, exp_q[v]); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int gidx[6];
    int gcyc[6];
    int exp_order[6];
    int n;
    exp_order = '{0, 1, 2, 3, 0, 1};
    n = 0;
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    req = 4'b1111; op_a = '0; op_b = '0; op_c = '0; rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (gnt !== 4'b0000) begin
        checks++; if (!$onehot(gnt)) begin errors++; $display("FAIL rr_onehot got=%b", gnt); end
        gidx[n] = 0;
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gidx[n] = i;
        gcyc[n] = c;
        n++;
      end
      tick();
    end
    req = '0;
    checks++; if (n !== 6) begin errors++; $display("FAIL rr_count got=%0d exp=6", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (gidx[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, gidx[i], exp_order[i]); end
    end
    for (int i = 1; i < n; i++) begin
      checks++; if (gcyc[i] - gcyc[i-1] !== 3) begin errors++; $display("FAIL rr_gap[%0d] got=%0d exp=3", i, gcyc[i] - gcyc[i-1]); end
    end
    tick(); tick(); tick();
  endtask

  // rr_ptr is 2 on entry; requester 1 alone with abc=000 gives q=1.
  task automatic test_backpressure();
    req = 4'b0010; op_a = '0; op_b = '0; op_c = '0; rsp_ready = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_gnt got=%b exp=0010", gnt); end
    tick();
    tick();
    for (int s = 0; s < 5; s++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid s=%0d got=%b exp=1", s, rsp_valid); end
      checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_id s=%0d got=%0d exp=1", s, rsp_id); end
      checks++; if (rsp_q !== 1'b1) begin errors++; $display("FAIL bp_q s=%0d got=%b exp=1", s, rsp_q); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt_stall s=%0d got=%b exp=0000", s, gnt); end
      op_a = ~op_a; op_b = ~op_b; op_c = (s % 2 == 0) ? 4'b0000 : 4'b1111;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hs got=%b exp=1", rsp_valid); end
    checks++; if (rsp_q !== 1'b1) begin errors++; $display("FAIL bp_q_hs got=%b exp=1", rsp_q); end
    tick();
    req = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    req = 4'b0001; op_a = 4'b0001; op_b = 4'b0001; op_c = 4'b0000; rsp_ready = 1'b1;
    tick();
    req = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmo_in_eval got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmo_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmo_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmo_no_rsp i=%0d got=%b exp=0", i, rsp_valid); end
    end
    req = 4'b1000; op_a = 4'b0000; op_b = 4'b1000; op_c = 4'b0000;
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rmo_gnt got=%b exp=1000", gnt); end
    tick();
    req = '0;
    tick();
    checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL rmo_id got=%0d exp=3", rsp_id); end
    checks++; if (rsp_q !== 1'b1) begin errors++; $display("FAIL rmo_q got=%b exp=1", rsp_q); end
    tick();
  endtask

  // rr_ptr wrapped to 0 after the grant to requester 3; grant 0 moves it to 1.
  task automatic test_dropped_request();
    req = 4'b0001; op_a = '0; op_b = '0; op_c = '0; rsp_ready = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_first_gnt got=%b exp=0001", gnt); end
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_gnt_resp got=%b exp=0000", gnt); end
    rsp_ready = 1'b1;
    tick();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_gnt_idle i=%0d got=%b exp=0000", i, gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy i=%0d got=%b exp=0", i, busy); end
      tick();
    end
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_rr_ptr got=%b exp=0010", gnt); end
    tick();
    req = '0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; op_c = '0; rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_truth_table();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_dropped_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
